// File: rtl/io_input_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : io_input_reader_if
// Description : Read-port bundle between the load/store peripheral decode
//               (master) and the input reader (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface io_input_reader_if;
    logic        rd_en;
    logic [1:0]  addr;
    logic [31:0] rd_data;
    logic        rd_valid;

    modport master (
        output rd_en,
        output addr,
        input  rd_data,
        input  rd_valid
    );

    modport slave (
        input  rd_en,
        input  addr,
        output rd_data,
        output rd_valid
    );
endinterface : io_input_reader_if
`default_nettype wire

// File: rtl/io_input_reader.sv
`default_nettype none
// ============================================================================
// Module      : io_input_reader
// Description : Memory-mapped switch/button reader. Synchronises and
//               (optionally, macro INPUT_DEBOUNCE_EN) debounces the pins,
//               keeps sticky press flags plus a saturating press counter,
//               and returns one selected word on a registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module io_input_reader #(
    parameter int SW_WIDTH   = 16,
    parameter int BTN_WIDTH  = 4,
    parameter int DEB_CYCLES = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic [SW_WIDTH-1:0]  sw,
    input  wire logic [BTN_WIDTH-1:0] btn,
    io_input_reader_if.slave          bus
);

    localparam int         c_N       = SW_WIDTH + BTN_WIDTH;
    localparam logic [7:0] c_CNT_SAT = 8'hFF;

    // Buttons occupy the upper bits of the combined pin vector
    logic [c_N-1:0]       r_s1;
    logic [c_N-1:0]       r_s2;
    logic [c_N-1:0]       w_d;
    logic [BTN_WIDTH-1:0] w_btn_next;
    logic [BTN_WIDTH-1:0] w_btn_rise;
    logic [BTN_WIDTH-1:0] r_evt;
    logic [7:0]           r_evt_cnt;
    logic [31:0]          w_rd_word;
    logic [31:0]          r_rd_data;
    logic                 r_rd_valid;
    logic                 w_rd_evt;
    logic                 w_rd_cnt;
    logic                 w_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= {btn, sw};
            r_s2 <= r_s1;
        end
    end

`ifdef INPUT_DEBOUNCE_EN
    localparam int                c_CNT_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEB_CYCLES - 1);

    logic [c_N-1:0] r_d;
    logic [c_N-1:0] w_d_next;

    // A bit is accepted only after differing from d for DEB_CYCLES cycles in a row
    for (genvar gi = 0; gi < c_N; gi++) begin : g_deb
        logic [c_CNT_W-1:0] r_cnt;

        assign w_d_next[gi] = ((r_s2[gi] != r_d[gi]) && (r_cnt == c_CNT_MAX))
                              ? r_s2[gi] : r_d[gi];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= '0;
            end else if ((r_s2[gi] == r_d[gi]) || (r_cnt == c_CNT_MAX)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d <= '0;
        end else begin
            r_d <= w_d_next;
        end
    end

    assign w_d        = r_d;
    assign w_btn_next = w_d_next[c_N-1:SW_WIDTH];
`else
    // Without debounce the stable value is the synchroniser output itself
    if (DEB_CYCLES < 1) begin : g_deb_cycles_unused
    end

    assign w_d        = r_s2;
    assign w_btn_next = r_s1[c_N-1:SW_WIDTH];
`endif

    // A press is a 0->1 change of the button's stable value on this edge
    assign w_btn_rise = w_btn_next & ~w_d[c_N-1:SW_WIDTH];
    assign w_inc      = |w_btn_rise;
    assign w_rd_evt   = bus.rd_en && (bus.addr == 2'd2);
    assign w_rd_cnt   = bus.rd_en && (bus.addr == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_evt <= '0;
        end else begin
            r_evt <= (w_rd_evt ? '0 : r_evt) | w_btn_rise;
        end
    end

    // A press coinciding with the clearing read survives as a count of one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_evt_cnt <= '0;
        end else if (w_rd_cnt) begin
            r_evt_cnt <= {7'd0, w_inc};
        end else if (w_inc && (r_evt_cnt != c_CNT_SAT)) begin
            r_evt_cnt <= r_evt_cnt + 8'd1;
        end
    end

    always_comb begin
        w_rd_word = '0;
        case (bus.addr)
            2'd0:    w_rd_word[SW_WIDTH-1:0]  = w_d[SW_WIDTH-1:0];
            2'd1:    w_rd_word[BTN_WIDTH-1:0] = w_d[c_N-1:SW_WIDTH];
            2'd2:    w_rd_word[BTN_WIDTH-1:0] = r_evt;
            default: w_rd_word[7:0]           = r_evt_cnt;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;

endmodule : io_input_reader
`default_nettype wire

// File: tb/tb_io_input_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_input_reader
// Description : Directed, table-driven bench for io_input_reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_input_reader;

    localparam int c_DEB = 4;
`ifdef INPUT_DEBOUNCE_EN
    localparam int c_LAT    = c_DEB + 2;
    localparam bit c_DEB_ON = 1'b1;
`else
    localparam int c_LAT    = 2;
    localparam bit c_DEB_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sw  = '0;
    logic [3:0]  btn = '0;

    int n_checks = 0;
    int n_fail   = 0;

    io_input_reader_if bus ();

    io_input_reader #(
        .SW_WIDTH   (16),
        .BTN_WIDTH  (4),
        .DEB_CYCLES (c_DEB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw),
        .btn (btn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sw;
        logic [3:0]  btn;
        logic [1:0]  addr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd_check(input logic [1:0] a, input logic [31:0] exp, input string name);
        bus.rd_en = 1'b1;
        bus.addr  = a;
        tick();
        check({name, " valid"}, {31'd0, bus.rd_valid}, 32'd1);
        check(name, bus.rd_data, exp);
        bus.rd_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp4 [4];

        vecs[0] = '{16'h0000, 4'h0, 2'd0, 32'h0000_0000, "tbl sw 0000"};
        vecs[1] = '{16'hA5A5, 4'h0, 2'd0, 32'h0000_A5A5, "tbl sw A5A5"};
        vecs[2] = '{16'h5A5A, 4'h3, 2'd1, 32'h0000_0003, "tbl btn 3"};
        vecs[3] = '{16'h8001, 4'h3, 2'd0, 32'h0000_8001, "tbl sw 8001"};
        vecs[4] = '{16'hFFFF, 4'hF, 2'd1, 32'h0000_000F, "tbl btn F"};
        vecs[5] = '{16'h0F0F, 4'h0, 2'd1, 32'h0000_0000, "tbl btn 0"};

        bus.rd_en = 1'b0;
        bus.addr  = 2'd0;
        tick(2);
        check("reset rd_data", bus.rd_data, 32'd0);
        check("reset rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        rst = 1'b0;

        // Async reset mid-cycle with switches held high
        sw = 16'hFFFF;
        tick(c_LAT + 2);
        rd_check(2'd0, 32'h0000_FFFF, "sw ffff before reset");
        #2 rst = 1'b1;
        #1;
        check("async rst rd_data", bus.rd_data, 32'd0);
        check("async rst rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(c_LAT - 1);
        rd_check(2'd0, 32'h0, "sw before latency");
        rd_check(2'd0, 32'h0000_FFFF, "sw after latency");

        for (int i = 0; i < 6; i++) begin
            sw  = vecs[i].sw;
            btn = vecs[i].btn;
            tick(c_LAT + 2);
            rd_check(vecs[i].addr, vecs[i].exp, vecs[i].name);
        end
        sw  = '0;
        btn = '0;
        tick(c_LAT + 2);
        rd_check(2'd2, 32'hF, "tbl evt flags");
        rd_check(2'd2, 32'h0, "tbl evt cleared");
        rd_check(2'd3, 32'd2, "tbl evt_cnt");
        rd_check(2'd3, 32'd0, "tbl evt_cnt cleared");

        // Short pulse: filtered with debounce, a press without it
        btn[0] = 1'b1;
        tick(c_DEB_ON ? 3 : 1);
        btn[0] = 1'b0;
        tick(c_LAT + 2);
        rd_check(2'd2, c_DEB_ON ? 32'h0 : 32'h1, "short pulse evt");
        rd_check(2'd3, c_DEB_ON ? 32'd0 : 32'd1, "short pulse cnt");

        btn[0] = 1'b1;
        tick(c_LAT - 1);
        rd_check(2'd1, 32'h0, "btn d before latency");
        rd_check(2'd1, 32'h1, "btn d after latency");
        tick(2);
        btn[0] = 1'b0;
        tick(c_LAT + 2);
        rd_check(2'd2, 32'h1, "held press evt");
        rd_check(2'd2, 32'h0, "held press evt cleared");
        rd_check(2'd3, 32'd1, "held press cnt");

        sw = 16'h0008;
        tick(c_LAT - 1);
        rd_check(2'd0, 32'h0, "sw3 before latency");
        rd_check(2'd0, 32'h8, "sw3 after latency");

        // Flag collision: btn[1] sets on the edge of the clearing read
        btn = 4'b0001;
        tick(c_LAT + 2);
        btn = 4'b0000;
        tick(c_LAT + 2);
        btn = 4'b0010;
        tick(c_LAT - 1);
        rd_check(2'd2, 32'h1, "collision evt read");
        rd_check(2'd2, 32'h2, "collision evt next");
        rd_check(2'd3, 32'd2, "collision evt_cnt");
        btn = 4'b0000;
        tick(c_LAT + 2);

        // Counter collision: press lands on the clearing read
        btn = 4'b0001;
        tick(c_LAT - 1);
        rd_check(2'd3, 32'd0, "cnt collision read");
        rd_check(2'd3, 32'd1, "cnt collision next");
        rd_check(2'd2, 32'h1, "cnt collision evt");
        btn = 4'b0000;
        tick(c_LAT + 2);

        for (int i = 0; i < 300; i++) begin
            btn[2] = 1'b1;
            tick(c_LAT + 1);
            btn[2] = 1'b0;
            tick(c_LAT + 1);
        end
        rd_check(2'd3, 32'd255, "cnt saturated");
        rd_check(2'd3, 32'd0, "cnt after clear");

        // Back-to-back reads across the whole map
        sw  = 16'h1234;
        btn = 4'b1000;
        tick(c_LAT + 2);
        exp4[0] = 32'h0000_1234;
        exp4[1] = 32'h0000_0008;
        exp4[2] = 32'h0000_000C;
        exp4[3] = 32'h0000_0001;
        for (int a = 0; a < 4; a++) begin
            rd_check(2'(a), exp4[a], $sformatf("b2b addr %0d", a));
        end
        tick();
        check("b2b valid low", {31'd0, bus.rd_valid}, 32'd0);
        check("b2b data held", bus.rd_data, 32'h1);
        tick(3);
        check("b2b data still held", bus.rd_data, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_io_input_reader
`default_nettype wire

// File: doc/io_input_reader.md
# io_input_reader

Memory-mapped input peripheral that the load path reads: synchronises raw switch and button pins, debounces them, latches button-press events in sticky flags, and returns a selected word on a registered read port. It is the read-side counterpart of the enabled output registers that store instructions write (LEDs, 7-segment). It sits inside the load/store unit's peripheral decode, which drives `rd_en`/`addr` for input-space loads.

## Interface
- `SW_WIDTH`, default 16: number of switch inputs; 1..32.
- `BTN_WIDTH`, default 4: number of push-button inputs; 1..8.
- `DEB_CYCLES`, default 16: cycles an input must stay stable before it is accepted; ≥1.

- `clk`  input  1: single clock; all state updates on rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `sw`  input  SW_WIDTH: raw switch pins, asynchronous to `clk`.
- `btn`  input  BTN_WIDTH: raw button pins, active-high, asynchronous.
- `rd_en`  input  1: read request this cycle.
- `addr`  input  2: word select, sampled when `rd_en`=1.
- `rd_data`  output  32: read result.
- `rd_valid`  output  1: high for exactly one cycle when `rd_data` holds a new result.

## Operation
- Every pin passes through a 2-flop synchroniser (`s1`→`s2`).
- Debounce, per bit, when compiled in (see Configuration): a per-bit counter holds 0 while `s2`==stable value `d`. While they differ it increments each cycle. When the counter equals DEB_CYCLES-1 and the bits still differ, `d` takes `s2` and the counter returns to 0. Any return to equality before that point resets the counter.
- Press event: when a button's `d` goes 0→1, its sticky flag `evt[i]` sets on that same edge.
- `evt_cnt`: 8-bit, increments once per edge in which at least one flag-setting 0→1 occurs. It saturates at 255.
- Read map (unused upper bits read 0):
  - addr 0: `d` of switches.
  - addr 1: `d` of buttons.
  - addr 2: `evt` flags; read-to-clear.
  - addr 3: `evt_cnt`. Reading clears it to 0.
- Read-to-clear: on an edge with `rd_en`=1, `addr`=2, every flag returned in `rd_data` clears.
  - If a new press on bit i happens on that same edge, `evt[i]` ends set. The returned data shows the pre-edge value.
  - Counter read works the same way: a simultaneous increment leaves `evt_cnt`=1.
- No read side effects for addr 0/1.

## Timing
- Reset (async assert, sampled de-assert): `s1`, `s2`, `d`, counters, `evt`, `evt_cnt`, `rd_data` = 0, `rd_valid` = 0.
  - A button held high through reset is therefore seen as a press after release of reset plus the debounce time.
- Input latency, debounce on: a pin change held stable is first sampled at edge 1. `d` updates at edge DEB_CYCLES+2.
- Input latency, debounce off: `d` equals `s2` and updates at edge 2.
- Read latency is 1 cycle: the request is presented in cycle n, and `rd_data`/`rd_valid` are valid after the edge ending cycle n.
  - `rd_data` holds its last value when no read occurs.
  - Back-to-back reads are allowed every cycle.
- Reset mid-operation discards pending debounce counts and unread flags.

## Configuration
- `INPUT_DEBOUNCE_EN` defined: per-bit debounce counters are instantiated, and `DEB_CYCLES` applies.
- `INPUT_DEBOUNCE_EN` undefined: no counters, `DEB_CYCLES` is ignored, and `d` = `s2`. Events are taken from `s2` 0→1 transitions.
- The read map and clear rules are identical in both builds.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle with `sw`=16'hFFFF held. All outputs read 0 immediately. After release, a read of addr 0 returns 0x0000FFFF only once the input latency has elapsed.
- Debounce (DEB_CYCLES=4): `btn[0]` glitch high for 3 cycles → addr 2 reads 0. Hold high for 6 cycles → `d` rises at edge 6, then addr 2 reads 0x1 and a second read returns 0x0.
- Collision: press `btn[1]` so its flag sets on the same edge as an addr 2 read while `evt`=0x1. `rd_data`=0x1, and the next read returns 0x2.
- Counter: 300 debounced presses on `btn[2]` → addr 3 returns 255, and an immediate re-read returns 0.
- Read timing: `rd_en` on 4 consecutive cycles with addr 0,1,2,3. `rd_valid` is high for the 4 following cycles, `rd_data` arrives in order with a one-cycle delay, and it is held afterwards.
- Build without `INPUT_DEBOUNCE_EN`: toggle `sw[3]` and observe `d` change at edge 2. A 1-cycle `btn[0]` pulse sets `evt[0]`.
